// File: rtl/mm_output_packer.sv
// mm_output_packer: compacts the valid columns of the enabled banks of each
// input beat into a left-aligned row, then packs rows back-to-back into full
// numElements-wide output lines. Rows that cross a line boundary spill over
// into the next line.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   start_i, cfg_*_i           latch column offset / column count / bank count
//   flush_i                    drain and emit any partial line, then go idle
//   valid_i, ready_o, data_i   input beat handshake and raw matmul outputs
//   valid_o, ready_i, data_o   packed output line handshake and payload
//   count_o                    valid elements in data_o (zero-filled above)
//   busy_o, cfg_err_o          not idle / one-cycle pulse on illegal start
module mm_output_packer #(
  parameter int unsigned numBanks       = 8,
  parameter int unsigned numColsPerBank = 32,
  parameter int unsigned elementBits    = 8,
  parameter int unsigned numElements    = 256
) (
  input  logic                                    clk,
  input  logic                                    nrst,
  input  logic                                    start_i,
  input  logic [$clog2(numColsPerBank)-1:0]       cfg_offset_i,
  input  logic [$clog2(numColsPerBank):0]         cfg_cols_i,
  input  logic [$clog2(numBanks):0]               cfg_banks_i,
  input  logic                                    flush_i,
  input  logic                                    valid_i,
  output logic                                    ready_o,
  input  logic [numElements-1:0][elementBits-1:0] data_i,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic [numElements-1:0][elementBits-1:0] data_o,
  output logic [$clog2(numElements):0]            count_o,
  output logic                                    busy_o,
  output logic                                    cfg_err_o
);

  localparam int unsigned OffW  = $clog2(numColsPerBank);
  localparam int unsigned ColW  = OffW + 1;
  localparam int unsigned BankW = $clog2(numBanks) + 1;
  localparam int unsigned FillW = $clog2(numElements);
  localparam int unsigned CntW  = FillW + 1;
  localparam int unsigned LineW = numElements * elementBits;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e                                  state_q, state_d;
  logic [OffW-1:0]                         off_q;
  logic [ColW-1:0]                         cols_q;
  logic [BankW-1:0]                        banks_q;
  logic [CntW-1:0]                         n_q;
  logic                                    cfg_err_q;
  logic                                    s1_valid_q, s1_valid_d;
  logic [numElements-1:0][elementBits-1:0] s1_row_q, s1_row_d;
  logic [numElements-1:0][elementBits-1:0] stage_q, stage_d;
  logic [FillW-1:0]                        fill_q, fill_d;
  logic                                    out_valid_q, out_valid_d;
  logic [numElements-1:0][elementBits-1:0] out_data_q, out_data_d;
  logic [CntW-1:0]                         out_count_q, out_count_d;

  logic                                    legal_c, cfg_load_c;
  logic                                    out_free_c, completes_c, absorb_c, emit_part_c, accept_c;
  logic [CntW-1:0]                         sum_c;
  logic [numElements-1:0][elementBits-1:0] row_c;
  logic [2*LineW-1:0]                      ext_c;

  // Start-time configuration check
  always_comb begin
    legal_c    = (cfg_cols_i != '0)
              && ((ColW'(cfg_offset_i) + cfg_cols_i) <= ColW'(numColsPerBank))
              && (cfg_banks_i != '0)
              && (cfg_banks_i <= BankW'(numBanks));
    cfg_load_c = (state_q == IDLE) && start_i && legal_c;
  end

  // Column compaction: bank b, column c lands at row slot b*cols+c
  always_comb begin
    row_c = '0;
    for (int b = 0; b < int'(numBanks); b++) begin
      for (int c = 0; c < int'(numColsPerBank); c++) begin
        if ((b < int'(banks_q)) && (c < int'(cols_q))) begin
          row_c[FillW'(b * int'(cols_q) + c)] =
            data_i[FillW'(b * int'(numColsPerBank) + int'(off_q) + c)];
        end
      end
    end
  end

  // Packer control; ext_c is the staging line with the row appended at slot F
  always_comb begin
    out_free_c  = !out_valid_q || ready_i;
    sum_c       = CntW'(fill_q) + n_q;
    completes_c = sum_c >= CntW'(numElements);
    absorb_c    = s1_valid_q && (!completes_c || out_free_c);
    emit_part_c = (state_q == FLUSH) && !s1_valid_q && (fill_q != '0) && out_free_c;
    accept_c    = valid_i && ready_o;
    ext_c       = ({{LineW{1'b0}}, s1_row_q} << (int'(fill_q) * int'(elementBits)))
                | {{LineW{1'b0}}, stage_q};
  end

  // Stage-1, staging line and output register next state
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_row_d    = s1_row_q;
    stage_d     = stage_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_row_d   = row_c;
    end else if (absorb_c) begin
      s1_valid_d = 1'b0;
    end
    if (absorb_c) begin
      if (completes_c) begin
        stage_d = ext_c[2*LineW-1:LineW];
        fill_d  = FillW'(sum_c - CntW'(numElements));
      end else begin
        stage_d = ext_c[LineW-1:0];
        fill_d  = FillW'(sum_c);
      end
    end else if (emit_part_c) begin
      stage_d = '0;
      fill_d  = '0;
    end
    if (absorb_c && completes_c) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_c[LineW-1:0];
      out_count_d = CntW'(numElements);
    end else if (emit_part_c) begin
      out_valid_d = 1'b1;
      out_data_d  = stage_q;
      out_count_d = CntW'(fill_q);
    end else if (ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i && legal_c) state_d = RUN;
      RUN:     if (flush_i) state_d = FLUSH;
      FLUSH:   if (!s1_valid_q && (fill_q == '0) && out_free_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; a held stage-1 row frees up in the same cycle it is absorbed
  always_comb begin
    ready_o = (state_q == RUN) && (!s1_valid_q || absorb_c);
    busy_o  = (state_q != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      off_q       <= '0;
      cols_q      <= '0;
      banks_q     <= '0;
      n_q         <= '0;
      cfg_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_row_q    <= '0;
      stage_q     <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      if (cfg_load_c) begin
        off_q   <= cfg_offset_i;
        cols_q  <= cfg_cols_i;
        banks_q <= cfg_banks_i;
        n_q     <= CntW'(cfg_cols_i) * CntW'(cfg_banks_i);
      end
      cfg_err_q   <= (state_q == IDLE) && start_i && !legal_c;
      s1_valid_q  <= s1_valid_d;
      s1_row_q    <= s1_row_d;
      stage_q     <= stage_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign valid_o   = out_valid_q;
  assign data_o    = out_data_q;
  assign count_o   = out_count_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_mm_output_packer.sv
module tb_mm_output_packer;

  localparam int NE = 256;
  localparam int NCB = 32;
  typedef logic [NE-1:0][7:0] line_t;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;
  logic [4:0] cfg_offset_i = '0;
  logic [5:0] cfg_cols_i = '0;
  logic [3:0] cfg_banks_i = '0;
  line_t      data_i = '0;
  line_t      data_o;
  logic       ready_o, valid_o, busy_o, cfg_err_o;
  logic [8:0] count_o;

  mm_output_packer dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .cfg_offset_i(cfg_offset_i),
    .cfg_cols_i(cfg_cols_i), .cfg_banks_i(cfg_banks_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .count_o(count_o), .busy_o(busy_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass = 0;

  // Reference model: flat element stream, cut into lines
  byte unsigned pend[$];
  line_t exp_lines[$];
  int    exp_cnts[$];
  line_t log_lines[$];
  int    log_cnts[$];
  int    xfer_cyc[$];
  int    cyc = 0, last_acc = 0, rise_cyc = -1;
  int    m_off = 0, m_cols = 0, m_banks = 0, m_n, m_idx, ec;
  bit    prev_hold = 0, prev_valid = 0, err_exp = 0, legal;
  line_t prev_data, el;
  int    prev_cnt;

  bit    rr_mode = 0;
  bit    ready_force = 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk_line(input string nm, input line_t got, input line_t exp);
    int first;
    first = -1;
    for (int i = 0; i < NE; i++) if (got[i] !== exp[i] && first < 0) first = i;
    n_total++;
    if (first < 0) n_pass++;
    else $display("FAIL %s: element %0d got %0h expected %0h", nm, first, got[first], exp[first]);
  endtask

  task automatic form_line(input int len);
    line_t l;
    l = '0;
    for (int i = 0; i < len; i++) l[i] = pend.pop_front();
    exp_lines.push_back(l);
    exp_cnts.push_back(len);
  endtask

  // Ready driver: random backpressure or a fixed level
  always @(posedge clk) begin
    #2;
    ready_i = rr_mode ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor: model update and per-cycle comparison
  always @(negedge clk) begin
    cyc++;
    if (!nrst) begin
      pend.delete(); exp_lines.delete(); exp_cnts.delete();
      prev_hold = 0; prev_valid = 0; err_exp = 0;
    end else begin
      chk("cfg_err_o", int'(cfg_err_o), int'(err_exp));
      if (prev_hold) begin
        chk("hold_valid", int'(valid_o), 1);
        chk("hold_count", int'(count_o), prev_cnt);
        chk_line("hold_data", data_o, prev_data);
      end
      if (valid_o && !prev_valid) rise_cyc = cyc;
      if (valid_o && ready_i) begin
        chk("line_expected", int'(exp_lines.size() > 0), 1);
        if (exp_lines.size() > 0) begin
          el = exp_lines.pop_front();
          ec = exp_cnts.pop_front();
          chk("line_count", int'(count_o), ec);
          chk_line("line_data", data_o, el);
        end
        log_lines.push_back(data_o);
        log_cnts.push_back(int'(count_o));
        xfer_cyc.push_back(cyc);
      end
      err_exp = 0;
      if (start_i && !busy_o) begin
        legal = (cfg_cols_i >= 1) && (int'(cfg_offset_i) + int'(cfg_cols_i) <= NCB)
             && (cfg_banks_i >= 1) && (cfg_banks_i <= 8);
        if (legal) begin
          m_off = int'(cfg_offset_i); m_cols = int'(cfg_cols_i); m_banks = int'(cfg_banks_i);
        end else err_exp = 1;
      end
      if (valid_i && ready_o) begin
        last_acc = cyc;
        m_n = m_cols * m_banks;
        for (int k = 0; k < m_n; k++) begin
          m_idx = (k / m_cols) * NCB + m_off + (k % m_cols);
          pend.push_back(data_i[m_idx]);
        end
        while (pend.size() >= NE) form_line(NE);
      end
      if (flush_i && busy_o && pend.size() > 0) form_line(pend.size());
      prev_hold  = valid_o && !ready_i;
      prev_valid = valid_o;
      prev_data  = data_o;
      prev_cnt   = int'(count_o);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int off, input int cols, input int banks);
    cfg_offset_i = 5'(off); cfg_cols_i = 6'(cols); cfg_banks_i = 4'(banks);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic send_beat(input line_t d, input bit with_flush);
    bit got;
    got = 0;
    valid_i = 1'b1; data_i = d; flush_i = with_flush;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
    valid_i = 1'b0;
    chk("beat_accepted", int'(got), 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = !busy_o && !valid_o;
    end
    chk("idle_reached", int'(ok), 1);
    tick();
  endtask

  task automatic clear_logs();
    log_lines.delete(); log_cnts.delete(); xfer_cyc.delete();
  endtask

  function automatic line_t ramp();
    line_t r;
    for (int e = 0; e < NE; e++) r[e] = 8'(e);
    return r;
  endfunction

  function automatic line_t rand_line();
    line_t r;
    for (int e = 0; e < NE; e++) r[e] = 8'($urandom);
    return r;
  endfunction

  line_t l0, l1, b2b[4], beat;
  line_t zero_line = '0;

  initial begin
    // Reset state
    #1;
    chk("rst_valid_o", int'(valid_o), 0);
    chk("rst_count_o", int'(count_o), 0);
    chk("rst_busy_o", int'(busy_o), 0);
    chk("rst_ready_o", int'(ready_o), 0);
    chk("rst_cfg_err_o", int'(cfg_err_o), 0);
    chk_line("rst_data_o", data_o, zero_line);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    tick();

    // Offset 4, 16 columns, 8 banks: two beats make one line
    do_start(4, 16, 8);
    clear_logs();
    send_beat(ramp(), 0);
    send_beat(ramp(), 0);
    do_flush();
    wait_idle();
    l0 = log_lines[0];
    chk("s1_lines", log_lines.size(), 1);
    chk("s1_count", log_cnts[0], 256);
    chk("s1_d0", int'(l0[0]), 4);
    chk("s1_d15", int'(l0[15]), 19);
    chk("s1_d16", int'(l0[16]), 36);
    chk("s1_d128", int'(l0[128]), 4);
    chk("s1_latency", rise_cyc - last_acc, 2);

    // N=192 with spill-over; flush raised together with the second beat
    do_start(0, 24, 8);
    clear_logs();
    send_beat(ramp(), 0);
    send_beat(ramp(), 1);
    wait_idle();
    l0 = log_lines[0];
    l1 = log_lines[1];
    chk("s2_lines", log_lines.size(), 2);
    chk("s2_count0", log_cnts[0], 256);
    chk("s2_count1", log_cnts[1], 128);
    chk("s2_d192", int'(l0[192]), 0);
    chk("s2_d216", int'(l0[216]), 32);
    chk("s2_tail_zero", int'(l1[255:128] == '0), 1);
    chk("s2_busy", int'(busy_o), 0);

    // Backpressure on the first line while a completing row waits in stage 1
    do_start(0, 24, 8);
    clear_logs();
    ready_force = 0;
    send_beat(rand_line(), 0);
    send_beat(rand_line(), 0);
    send_beat(rand_line(), 0);
    repeat (2) tick();
    @(negedge clk);
    chk("s3_ready_stall", int'(ready_o), 0);
    chk("s3_valid_held", int'(valid_o), 1);
    chk("s3_count_held", int'(count_o), 256);
    tick();
    repeat (10) tick();
    ready_force = 1;
    do_flush();
    wait_idle();
    chk("s3_lines", log_lines.size(), 3);
    chk("s3_count2", log_cnts[2], 64);

    // Illegal start: offset 20 + 16 columns overruns the bank
    do_start(20, 16, 8);
    chk("s4_err_pulse", int'(cfg_err_o), 1);
    chk("s4_busy", int'(busy_o), 0);
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_ready", int'(ready_o), 0);
      chk("s4_busy_low", int'(busy_o), 0);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    chk("s4_err_done", int'(cfg_err_o), 0);

    // Full-width rows, back to back
    do_start(0, 32, 8);
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      b2b[i] = rand_line();
      send_beat(b2b[i], 0);
    end
    do_flush();
    wait_idle();
    chk("s5_lines", log_lines.size(), 4);
    chk("s5_b2b", xfer_cyc[3] - xfer_cyc[0], 3);
    for (int i = 0; i < 4; i++) begin
      chk("s5_count", log_cnts[i], 256);
      chk_line("s5_data", log_lines[i], b2b[i]);
    end

    // Randomized configs, gaps and backpressure
    rr_mode = 1;
    for (int it = 0; it < 12; it++) begin
      int cols, off, banks, nb;
      cols  = $urandom_range(1, 32);
      off   = $urandom_range(0, 32 - cols);
      banks = $urandom_range(1, 8);
      nb    = $urandom_range(1, 6);
      do_start(off, cols, banks);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat(rand_line(), 0);
      end
      do_flush();
      wait_idle();
    end
    rr_mode = 0;
    ready_force = 1;
    repeat (3) tick();

    // Reset mid-run with a 64-element partial staged
    do_start(0, 16, 4);
    send_beat(rand_line(), 0);
    repeat (3) tick();
    nrst = 1'b0;
    #1;
    chk("r_valid_o", int'(valid_o), 0);
    chk("r_count_o", int'(count_o), 0);
    chk("r_busy_o", int'(busy_o), 0);
    chk("r_ready_o", int'(ready_o), 0);
    chk("r_cfg_err_o", int'(cfg_err_o), 0);
    chk_line("r_data_o", data_o, zero_line);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    tick();
    do_start(0, 32, 8);
    clear_logs();
    beat = rand_line();
    send_beat(beat, 0);
    do_flush();
    wait_idle();
    chk("r_lines", log_lines.size(), 1);
    chk("r_count", log_cnts[0], 256);
    chk_line("r_clean", log_lines[0], beat);

    chk("no_leftover", exp_lines.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
